fret_bank: RTL and testbench

Parametrised N-channel note detector for the guitar-player datapath, all on the pixel clock. Samples one configurable pixel per channel from the incoming video stream, applies per-channel on/off colour hysteresis once per frame, generates a strum pulse train on new notes, and delays frets+strum by a runtime-selectable number of frames. Replaces the per-fret detector instances, the strum controller and the delay stage with one block that scales in channel count and delay depth.

---
 rtl/fret_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_fret_bank.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fret_bank.sv
// N-channel note detector: samples one pixel per channel, applies colour hysteresis
// once per frame, drives a strum pulse train and delays frets+strum by whole frames.
module fret_bank #(
  parameter int NCH  = 5,
  parameter int XW   = 11,
  parameter int YW   = 10,
  parameter int DMAX = 32,
  parameter int DW   = 5,
  parameter int SW   = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              enable,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              vde,
  input  logic [23:0]       rgb,
  input  logic [NCH*XW-1:0] pos_x,
  input  logic [NCH*YW-1:0] pos_y,
  input  logic [NCH*24-1:0] trig_on,
  input  logic [NCH*24-1:0] trig_off,
  input  logic [DW-1:0]     delay,
  input  logic [SW-1:0]     strum_time,
  output logic [NCH-1:0]    frets,
  output logic              strum,
  output logic [NCH-1:0]    press_raw,
  output logic              frame_tick
);

  localparam int AW = (DMAX > 1) ? $clog2(DMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STRUM,
    S_GAP
  } strum_state_e;

  logic           hs1, hs2, vs1, vs2, vde_d;
  logic           h_pulse, v_pulse;
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;

  logic [NCH-1:0] hit, on_hit, off_hit;
  logic [NCH-1:0] seen, on_m, off_m;
  logic [NCH-1:0] press, press_next;
  logic           new_note;

  strum_state_e   state, state_next;
  logic [SW-1:0]  cnt, cnt_next;
  logic           pend, pend_next;
  logic           strum_raw, strum_raw_next;

  logic [NCH:0]   dline [DMAX];
  logic [AW-1:0]  d_sel;
  logic [NCH:0]   tap;

  // Sync edge detectors; frame_tick is v_pulse delayed by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!RST_N) begin
      hs1        <= 1'b0;
      hs2        <= 1'b0;
      vs1        <= 1'b0;
      vs2        <= 1'b0;
      vde_d      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hs1        <= hsync;
      hs2        <= hs1;
      vs1        <= vsync;
      vs2        <= vs1;
      vde_d      <= vde;
      frame_tick <= v_pulse;
    end
  end

  assign h_pulse = hs1 & ~hs2;
  assign v_pulse = vs1 & ~vs2;

  // Pixel coordinates; x is the current pixel's column before the increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (h_pulse)
        x_cnt <= '0;
      else if (vde && x_cnt != '1)
        x_cnt <= x_cnt + 1'b1;

      if (v_pulse)
        y_cnt <= '0;
      else if (vde_d && !vde && y_cnt != '1)
        y_cnt <= y_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i]     = vde && (x_cnt == pos_x[i*XW +: XW]) && (y_cnt == pos_y[i*YW +: YW]);
      on_hit[i]  = (rgb[23:16] >= trig_on[i*24+16 +: 8]) &&
                   (rgb[15:8]  >= trig_on[i*24+8  +: 8]) &&
                   (rgb[7:0]   >= trig_on[i*24    +: 8]);
      off_hit[i] = (rgb[23:16] <= trig_off[i*24+16 +: 8]) &&
                   (rgb[15:8]  <= trig_off[i*24+8  +: 8]) &&
                   (rgb[7:0]   <= trig_off[i*24    +: 8]);
    end
  end

  // A hit in the frame_tick cycle belongs to the new frame, so it wins over the clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seen  <= '0;
      on_m  <= '0;
      off_m <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (hit[i]) begin
          seen[i]  <= 1'b1;
          on_m[i]  <= on_hit[i];
          off_m[i] <= off_hit[i];
        end else if (frame_tick) begin
          seen[i]  <= 1'b0;
          on_m[i]  <= 1'b0;
          off_m[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    press_next = press;
    if (frame_tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (seen[i] && on_m[i])
          press_next[i] = 1'b1;
        else if (seen[i] && off_m[i])
          press_next[i] = 1'b0;
      end
    end
  end

  assign new_note = |(press_next & ~press);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) press <= '0;
    else        press <= press_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      pend  <= pend_next;
    end
  end

  // GAP forces strum low for exactly one frame before a re-strum.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend;
    if (frame_tick) begin
      case (state)
        S_IDLE: begin
          if (new_note && strum_time != '0) begin
            state_next = S_STRUM;
            cnt_next   = strum_time;
          end
        end
        S_STRUM: begin
          if (new_note) begin
            state_next = S_GAP;
            pend_next  = 1'b1;
          end else if (cnt == SW'(1)) begin
            state_next = S_GAP;
            pend_next  = 1'b0;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        S_GAP: begin
          pend_next = 1'b0;
          if (pend && strum_time != '0) begin
            state_next = S_STRUM;
            cnt_next   = strum_time;
          end else begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign strum_raw      = (state == S_STRUM);
  assign strum_raw_next = (state_next == S_STRUM);

  // Entry 0 loads the post-update value, so it always mirrors {strum_raw, press}
  // and entry k holds the value from k frame_ticks earlier.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: the delay line is reset because the first frames after reset must read as zero.
    if (!RST_N) begin
      for (int j = 0; j < DMAX; j++) dline[j] <= '0;
    end else if (frame_tick) begin
      dline[0] <= {strum_raw_next, press_next};
      for (int j = 1; j < DMAX; j++) dline[j] <= dline[j-1];
    end
  end

  always_comb begin
    d_sel = AW'(DMAX - 1);
    if (32'(delay) < 32'(DMAX)) d_sel = AW'(delay);
  end

  assign tap       = dline[d_sel];
  assign frets     = enable ? tap[NCH-1:0] : '0;
  assign strum     = enable & tap[NCH];
  assign press_raw = press;

endmodule

// File: tb/tb_fret_bank.sv
// Self-checking bench for fret_bank: directed steps plus random colours, checked
// against a frame-timeline reference model.
module tb_fret_bank;

  localparam int NCH    = 5;
  localparam int XW     = 11;
  localparam int YW     = 10;
  localparam int DMAX   = 8;
  localparam int DW     = 5;
  localparam int SW     = 4;
  localparam int NPIX   = 24;
  localparam int NLINES = 6;
  localparam int MAXF   = 512;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              enable, hsync, vsync, vde;
  logic [23:0]       rgb;
  logic [NCH*XW-1:0] pos_x;
  logic [NCH*YW-1:0] pos_y;
  logic [NCH*24-1:0] trig_on, trig_off;
  logic [DW-1:0]     delay;
  logic [SW-1:0]     strum_time;
  logic [NCH-1:0]    frets, press_raw;
  logic              strum, frame_tick;

  fret_bank #(.NCH(NCH), .XW(XW), .YW(YW), .DMAX(DMAX), .DW(DW), .SW(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .hsync(hsync), .vsync(vsync),
    .vde(vde), .rgb(rgb), .pos_x(pos_x), .pos_y(pos_y), .trig_on(trig_on),
    .trig_off(trig_off), .delay(delay), .strum_time(strum_time), .frets(frets),
    .strum(strum), .press_raw(press_raw), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  logic [XW-1:0] px_pos  [NCH];
  logic [YW-1:0] py_pos  [NCH];
  logic [23:0]   on_thr  [NCH];
  logic [23:0]   off_thr [NCH];
  logic [23:0]   cur_col [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pos_x[i*XW +: XW]    = px_pos[i];
      pos_y[i*YW +: YW]    = py_pos[i];
      trig_on[i*24 +: 24]  = on_thr[i];
      trig_off[i*24 +: 24] = off_thr[i];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame index n counts frame_ticks since reset; hi/gp mark frames
  // in which strum is high / in its one-frame gap; rs marks a deferred re-strum load.
  int             n;
  logic [NCH-1:0] m_press;
  bit             hi [MAXF];
  bit             gp [MAXF];
  bit             rs [MAXF];
  logic [NCH:0]   hist [MAXF];
  bit             pend_seen [NCH];
  logic [23:0]    pend_col  [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_on(input logic [23:0] c, input logic [23:0] t);
    return c[23:16] >= t[23:16] && c[15:8] >= t[15:8] && c[7:0] >= t[7:0];
  endfunction

  function automatic bit is_off(input logic [23:0] c, input logic [23:0] t);
    return c[23:16] <= t[23:16] && c[15:8] <= t[15:8] && c[7:0] <= t[7:0];
  endfunction

  task automatic model_reset();
    n = 0;
    m_press = '0;
    for (int k = 0; k < MAXF; k++) begin
      hi[k] = 0; gp[k] = 0; rs[k] = 0; hist[k] = '0;
    end
    for (int i = 0; i < NCH; i++) pend_seen[i] = 0;
  endtask

  task automatic strum_load(input int f, input int st);
    for (int k = f; k < f + st; k++) hi[k] = 1;
    if (st != 0) gp[f + st] = 1;
  endtask

  task automatic model_tick();
    logic [NCH-1:0] nxt;
    bit nn;
    int st;
    n++;
    nxt = m_press;
    for (int i = 0; i < NCH; i++) begin
      if (pend_seen[i]) begin
        if (is_on(pend_col[i], on_thr[i]))        nxt[i] = 1'b1;
        else if (is_off(pend_col[i], off_thr[i])) nxt[i] = 1'b0;
      end
    end
    nn = |(nxt & ~m_press);
    m_press = nxt;
    st = int'(strum_time);
    if (nn) begin
      if (hi[n-1]) begin
        for (int k = n; k < MAXF; k++) begin hi[k] = 0; gp[k] = 0; end
        gp[n] = 1;
        rs[n+1] = 1;
      end else if (!gp[n-1]) begin
        strum_load(n, st);
      end
    end
    if (rs[n]) strum_load(n, st);
    hist[n] = {hi[n], m_press};
    for (int i = 0; i < NCH; i++) pend_seen[i] = 0;
  endtask

  task automatic check_outputs();
    int d, idx;
    logic [NCH:0] tap;
    d   = (int'(delay) > DMAX - 1) ? DMAX - 1 : int'(delay);
    idx = n - d;
    tap = (idx >= 0) ? hist[idx] : '0;
    check($sformatf("press_raw n=%0d", n), 32'(press_raw), 32'(m_press));
    check($sformatf("frets n=%0d d=%0d", n, d), 32'(frets), enable ? 32'(tap[NCH-1:0]) : 32'd0);
    check($sformatf("strum n=%0d d=%0d", n, d), 32'(strum), enable ? 32'(tap[NCH]) : 32'd0);
  endtask

  // One frame: vsync (tick applies the previous frame's samples), then NLINES lines
  // showing cur_col at each channel's sample point. rst_line >= 0 pulses reset mid-line.
  task automatic run_frame(input int rst_line);
    bit got;
    logic [23:0] pix;
    @(negedge CLK);
    vsync = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge CLK);
      if (frame_tick === 1'b1) got = 1;
    end
    check("frame_tick seen", 32'(got), 32'd1);
    model_tick();
    @(negedge CLK);
    vsync = 1'b0;
    check("frame_tick width", 32'(frame_tick), 32'd0);
    check_outputs();
    for (int ln = 0; ln < NLINES; ln++) begin
      @(negedge CLK); hsync = 1'b1;
      @(negedge CLK); hsync = 1'b0;
      repeat (3) @(negedge CLK);
      for (int px = 0; px < NPIX; px++) begin
        pix = 24'($urandom);
        for (int i = 0; i < NCH; i++)
          if (px_pos[i] == XW'(px) && py_pos[i] == YW'(ln)) pix = cur_col[i];
        vde = 1'b1;
        rgb = pix;
        if (ln == rst_line && px == NPIX / 2) begin
          RST_N = 1'b0;
          #1;
          check("reset press_raw", 32'(press_raw), 32'd0);
          check("reset frets", 32'(frets), 32'd0);
          check("reset strum", 32'(strum), 32'd0);
          check("reset frame_tick", 32'(frame_tick), 32'd0);
        end
        @(negedge CLK);
      end
      vde = 1'b0;
      rgb = '0;
      repeat (4) @(negedge CLK);
    end
    if (rst_line >= 0) begin
      RST_N = 1'b1;
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pend_seen[i] = (int'(py_pos[i]) < NLINES) && (int'(px_pos[i]) < NPIX);
        pend_col[i]  = cur_col[i];
      end
    end
  endtask

  function automatic logic [23:0] pick(input int i, input int cls);
    logic [23:0] c;
    logic [23:0] on_c, off_c;
    on_c  = on_thr[i];
    off_c = off_thr[i];
    for (int k = 0; k < 3; k++) begin
      case (cls)
        0:       c[k*8 +: 8] = 8'($urandom_range(int'(on_c[k*8 +: 8]), 255));
        1:       c[k*8 +: 8] = 8'($urandom_range(0, int'(off_c[k*8 +: 8])));
        default: c[k*8 +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return c;
  endfunction

  task automatic set_all(input logic [23:0] c);
    for (int i = 0; i < NCH; i++) cur_col[i] = c;
  endtask

  task automatic random_frames(input int cnt, input bit rand_delay, input bit rand_st);
    for (int f = 0; f < cnt; f++) begin
      for (int i = 0; i < NCH; i++) cur_col[i] = pick(i, int'($urandom_range(0, 2)));
      if (rand_delay) delay = DW'($urandom_range(0, 31));
      if (rand_st)    strum_time = SW'($urandom_range(0, 6));
      run_frame(-1);
    end
  endtask

  initial begin
    RST_N = 1'b0; enable = 1'b1; hsync = 1'b0; vsync = 1'b0; vde = 1'b0; rgb = '0;
    delay = '0; strum_time = '0;
    for (int i = 0; i < NCH; i++) begin
      px_pos[i]  = XW'(3 + 4 * i);
      py_pos[i]  = YW'(i + 1);
      on_thr[i]  = {8'($urandom_range(96, 192)), 8'($urandom_range(96, 192)), 8'($urandom_range(96, 192))};
      off_thr[i] = {8'($urandom_range(16, 80)), 8'($urandom_range(16, 80)), 8'($urandom_range(16, 80))};
    end
    on_thr[0]  = 24'h808080;
    off_thr[0] = 24'h202020;
    set_all(24'h000000);
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst frets", 32'(frets), 32'd0);
    check("rst strum", 32'(strum), 32'd0);
    check("rst press_raw", 32'(press_raw), 32'd0);
    check("rst frame_tick", 32'(frame_tick), 32'd0);
    RST_N = 1'b1;

    // Press / release on ch0 with delay 0, then hold on in-between colour and on missed sample.
    run_frame(-1);
    cur_col[0] = 24'hFFFFFF; run_frame(-1);
    cur_col[0] = 24'h000000; run_frame(-1);
    cur_col[0] = 24'hFFFFFF; run_frame(-1);
    cur_col[0] = 24'h505050; run_frame(-1);
    run_frame(-1);
    py_pos[0] = YW'(1023); cur_col[0] = 24'h000000;
    run_frame(-1); run_frame(-1); run_frame(-1);
    py_pos[0] = YW'(1);
    run_frame(-1); run_frame(-1);

    // Single strum of 3 frames, then disabled strum.
    strum_time = SW'(3);
    cur_col[2] = 24'hFFFFFF;
    repeat (6) run_frame(-1);
    cur_col[2] = 24'h000000;
    repeat (2) run_frame(-1);
    strum_time = SW'(0);
    cur_col[1] = 24'hFFFFFF;
    repeat (3) run_frame(-1);
    cur_col[1] = 24'h000000;
    repeat (2) run_frame(-1);

    // Re-strum: second note one frame into a 4-frame strum.
    strum_time = SW'(4);
    cur_col[3] = 24'hFFFFFF; run_frame(-1);
    cur_col[1] = 24'hFFFFFF;
    repeat (9) run_frame(-1);
    set_all(24'h000000);
    repeat (2) run_frame(-1);

    // Overlapping thresholds: on has priority.
    on_thr[4]  = 24'h101010;
    off_thr[4] = 24'hF0F0F0;
    cur_col[4] = 24'h808080;
    repeat (2) run_frame(-1);
    on_thr[4]  = 24'h909090;
    off_thr[4] = 24'h303030;

    // Delayed outputs, clamped delay, per-frame delay and strum length changes.
    delay = DW'(3);
    random_frames(12, 1'b0, 1'b0);
    delay = DW'(31);
    random_frames(10, 1'b0, 1'b0);
    random_frames(12, 1'b1, 1'b1);

    // Output gate closed while internal state keeps running.
    enable = 1'b0;
    delay  = DW'(0);
    random_frames(6, 1'b0, 1'b0);
    enable = 1'b1;

    // Reset while strumming, then delay 3 after reset.
    strum_time = SW'(5);
    set_all(24'h000000);
    repeat (8) run_frame(-1);
    cur_col[0] = 24'hFFFFFF;
    run_frame(-1);
    run_frame(-1);
    check("strum high before reset", 32'(strum), 32'd1);
    run_frame(2);
    delay = DW'(3);
    set_all(24'hFFFFFF);
    repeat (7) run_frame(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
